datapath_unit: RTL

DATAPATH_UNIT -- requirements
Module: datapath_unit

---
 rtl/datapath_unit.sv | 112 +++++++++++
 1 files changed

// File: rtl/datapath_unit.sv
// Datapath: ALU with B-operand select, 2^ADDR_BITS-word data memory with
// edge-triggered stores, registered result/flags and a committed-store counter.
module datapath_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] operand1,
    input  logic [DATA_WIDTH-1:0] operand2,
    input  logic [DATA_WIDTH-1:0] offset,
    input  logic [3:0]            opcode,
    input  logic                  sel1,
    input  logic                  sel3,
    input  logic                  w_r,
    output logic [DATA_WIDTH-1:0] result2,
    output logic                  zero_flag,
    output logic                  carry_flag,
    output logic [7:0]            store_count
);

    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned AW    = ADDR_BITS;
    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_SHL  = 4'b0110;
    localparam logic [3:0] OP_SHR  = 4'b0111;
    localparam logic [3:0] OP_ADC  = 4'b1000;
    localparam logic [3:0] OP_PASB = 4'b1001;
    localparam logic [3:0] OP_PASA = 4'b1010;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    logic [DW-1:0] alu_b;
    logic [2:0]    shamt;
    logic [DW:0]   add_w;
    logic [DW:0]   adc_w;
    logic [DW:0]   sub_w;
    logic [DW:0]   shl_w;
    logic [DW:0]   shr_w;
    logic [DW-1:0] result1;
    logic          carry1;
    logic [AW-1:0] addr;
    logic          store_fire;
    logic          w_r_q;
    logic [DW-1:0] mem [DEPTH];

    // ALU: arithmetic in DW+1 bits so the top bit carries carry/borrow
    always_comb begin
        alu_b   = sel3 ? offset : operand2;
        shamt   = alu_b[2:0];
        add_w   = {1'b0, operand1} + {1'b0, alu_b};
        adc_w   = add_w + {{DW{1'b0}}, carry_flag};
        sub_w   = {1'b0, operand1} - {1'b0, alu_b};
        // Extra bit on the shifted-out side captures the last bit lost
        shl_w   = {1'b0, operand1} << shamt;
        shr_w   = {operand1, 1'b0} >> shamt;
        result1 = '0;
        carry1  = 1'b0;
        case (opcode)
            OP_ADD:  {carry1, result1} = add_w;
            OP_SUB:  {carry1, result1} = sub_w;
            OP_AND:  result1 = operand1 & alu_b;
            OP_OR:   result1 = operand1 | alu_b;
            OP_XOR:  result1 = operand1 ^ alu_b;
            OP_NOT:  result1 = ~operand1;
            OP_SHL:  {carry1, result1} = shl_w;
            OP_SHR: begin
                result1 = shr_w[DW:1];
                carry1  = shr_w[0];
            end
            OP_ADC:  {carry1, result1} = adc_w;
            OP_PASB: result1 = alu_b;
            OP_PASA: result1 = operand1;
            default: result1 = '0;
        endcase
    end

    assign addr       = result1[AW-1:0];
    assign store_fire = w_r & ~w_r_q;

    // Stores commit only on the rising edge of w_r; reset preloads mem[i] = i
    always_ff @(posedge clk) begin
        if (rst) begin
            result2     <= '0;
            zero_flag   <= 1'b1;
            carry_flag  <= 1'b0;
            store_count <= 8'd0;
            w_r_q       <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= DW'(i);
            end
        end else begin
            w_r_q <= w_r;
            if (store_fire) begin
                mem[addr]   <= operand2;
                store_count <= store_count + 8'd1;
            end
            if (opcode != OP_NOP) begin
                result2    <= sel1 ? result1 : (w_r ? operand2 : mem[addr]);
                zero_flag  <= (result1 == '0);
                carry_flag <= carry1;
            end
        end
    end

endmodule
